// File: rtl/mult_rr_arbiter_if.sv
// Bundles the requester, response and multiplier-side signals of mult_rr_arbiter.
// slave: the arbiter's view.  master: the environment's view (requesters,
// response consumer and multiplier core).
interface mult_rr_arbiter_if #(
    parameter int SZ   = 32,
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*SZ-1:0] req_a;
    logic [NREQ*SZ-1:0] req_b;
    logic [NREQ-1:0]    req_ready;

    logic               res_valid;
    logic [2*SZ-1:0]    res_data;
    logic [IDW-1:0]     res_id;
    logic               res_err;
    logic               res_ready;

    logic [SZ-1:0]      m_a;
    logic [SZ-1:0]      m_b;
    logic               m_start;
    logic [2*SZ-1:0]    m_res;
    logic               m_ready;

    modport slave (
        input  req_valid, req_a, req_b, res_ready, m_res, m_ready,
        output req_ready, res_valid, res_data, res_id, res_err, m_a, m_b, m_start
    );

    modport master (
        output req_valid, req_a, req_b, res_ready, m_res, m_ready,
        input  req_ready, res_valid, res_data, res_id, res_err, m_a, m_b, m_start
    );
endinterface

// File: rtl/mult_rr_arbiter.sv
// Round-robin front end that shares one sequential multiplier among NREQ
// requesters. One operation is in flight at a time: accept, pulse start,
// skip one settle cycle, wait for the multiplier, then hold the tagged
// product until the consumer takes it.
// Optional feature: define MULT_ARB_TIMEOUT_EN to add a watchdog on the
// multiplier wait (TIMEOUT cycles) that returns res_err=1 with res_data=0.
module mult_rr_arbiter #(
    parameter int SZ      = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  _rst,
    mult_rr_arbiter_if.slave      bus
);
    localparam int IDW = $clog2(NREQ);

    if (NREQ < 2 || TIMEOUT < 1) begin : g_param_check
        $error("mult_rr_arbiter: NREQ must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SETTLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  last_q, last_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [SZ-1:0]   a_q, a_d;
    logic [SZ-1:0]   b_q, b_d;
    logic [2*SZ-1:0] data_q, data_d;
    logic [IDW-1:0]  grant;
    logic            grant_vld;
    logic [NREQ-1:0] req_ready_c;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    // Round-robin search: first valid requester after the last one granted.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_vld && bus.req_valid[IDW'((int'(last_q) + k) % NREQ)]) begin
                grant_vld = 1'b1;
                grant     = IDW'((int'(last_q) + k) % NREQ);
            end
        end
    end

    // Next-state logic: sequence accept, start, settle, wait and response.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        data_d      = data_q;
        req_ready_c = '0;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    req_ready_c[grant] = 1'b1;
                    a_d     = bus.req_a[grant*SZ +: SZ];
                    b_d     = bus.req_b[grant*SZ +: SZ];
                    id_d    = grant;
                    last_d  = grant;
                    state_d = ST_START;
                end
            end
            ST_START:  state_d = ST_SETTLE;
            // The multiplier may still show the previous ready here, so it is ignored.
            ST_SETTLE: begin
                state_d = ST_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (bus.m_ready) begin
                    data_d  = bus.m_res;
                    state_d = ST_RESP;
`ifdef MULT_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= ST_IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Accept is combinational in IDLE but forced low while reset is held.
    assign bus.req_ready = _rst ? req_ready_c : '0;
    assign bus.m_start   = (state_q == ST_START);
    assign bus.m_a       = a_q;
    assign bus.m_b       = b_q;
    assign bus.res_valid = (state_q == ST_RESP);
    assign bus.res_data  = data_q;
    assign bus.res_id    = id_q;
`ifdef MULT_ARB_TIMEOUT_EN
    assign bus.res_err   = err_q;
`else
    assign bus.res_err   = 1'b0;
`endif
endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Bench for mult_rr_arbiter: a multiplier stub with programmable latency, a
// transaction-level reference model checked on every falling edge, directed
// scenarios with literal expectations, then a randomized phase.
module tb_mult_rr_arbiter;
    localparam int SZ      = 32;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic _rst;
    logic stub_rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mult_rr_arbiter_if #(.SZ(SZ), .NREQ(NREQ)) bus ();

    mult_rr_arbiter #(.SZ(SZ), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        ._rst (_rst),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Multiplier stub: ready stays high for one cycle after start (stale),
    // then drops, then rises with the product after stub_lat more cycles.
    int            stub_lat;
    bit            stub_hold;
    bit            stub_run, stub_first;
    int            stub_cnt;
    logic [SZ-1:0] op_a, op_b;

    always @(posedge clk or negedge stub_rst_n) begin
        if (!stub_rst_n) begin
            bus.m_ready <= 1'b1;
            bus.m_res   <= '0;
            stub_run    <= 1'b0;
            stub_first  <= 1'b0;
            stub_cnt    <= 0;
            op_a        <= '0;
            op_b        <= '0;
        end else if (bus.m_start) begin
            op_a       <= bus.m_a;
            op_b       <= bus.m_b;
            stub_cnt   <= stub_lat;
            stub_run   <= 1'b1;
            stub_first <= 1'b1;
        end else if (stub_run) begin
            if (stub_first) begin
                bus.m_ready <= 1'b0;
                stub_first  <= 1'b0;
                stub_cnt    <= stub_cnt - 1;
            end else if (stub_cnt <= 0 && !stub_hold) begin
                bus.m_ready <= 1'b1;
                bus.m_res   <= 64'(op_a) * 64'(op_b);
                stub_run    <= 1'b0;
            end else if (stub_cnt > 0) begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: one transaction at a time, tracked by cycles since accept.
    bit          mdl_busy, mdl_resp, mdl_err;
    int          mdl_age, mdl_last, mdl_id;
    logic [31:0] mdl_a, mdl_b;
    logic [63:0] mdl_data;

    always @(negedge clk) begin : cmp
        logic [NREQ-1:0] exp_rdy;
        int              g;
        if (!_rst) begin
            check("rst_req_ready", bus.req_ready, 0);
            check("rst_res_valid", bus.res_valid, 0);
            check("rst_res_data",  bus.res_data,  0);
            check("rst_res_id",    bus.res_id,    0);
            check("rst_res_err",   bus.res_err,   0);
            check("rst_m_start",   bus.m_start,   0);
            check("rst_m_a",       bus.m_a,       0);
            check("rst_m_b",       bus.m_b,       0);
            mdl_busy = 0;
            mdl_resp = 0;
            mdl_last = NREQ - 1;
        end else begin
            exp_rdy = '0;
            g       = -1;
            if (!mdl_busy) begin
                g = rr_pick(bus.req_valid, mdl_last);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            check("req_ready", bus.req_ready, exp_rdy);
            check("m_start",   bus.m_start, mdl_busy && !mdl_resp && mdl_age == 1);
            if (mdl_busy && !mdl_resp) begin
                check("m_a", bus.m_a, mdl_a);
                check("m_b", bus.m_b, mdl_b);
            end
            check("res_valid", bus.res_valid, mdl_resp);
            if (mdl_resp) begin
                check("res_data", bus.res_data, mdl_data);
                check("res_id",   bus.res_id,   mdl_id);
                check("res_err",  bus.res_err,  mdl_err);
            end
            if (!mdl_busy) begin
                if (g >= 0) begin
                    mdl_last = g;
                    mdl_id   = g;
                    mdl_a    = bus.req_a[g*SZ +: SZ];
                    mdl_b    = bus.req_b[g*SZ +: SZ];
                    mdl_busy = 1;
                    mdl_age  = 1;
                end
            end else if (mdl_resp) begin
                if (bus.res_ready) begin
                    mdl_busy = 0;
                    mdl_resp = 0;
                end
            end else begin
                if (mdl_age >= 3 && bus.m_ready) begin
                    mdl_resp = 1;
                    mdl_data = 64'(mdl_a) * 64'(mdl_b);
                    mdl_err  = 0;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (mdl_age >= TIMEOUT + 2) begin
                    mdl_resp = 1;
                    mdl_data = '0;
                    mdl_err  = 1;
                end
`endif
                mdl_age++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        _rst          = 1'b0;
        bus.req_valid = '0;
        repeat (2) tick();
        _rst = 1'b1;
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        repeat (40) tick();
    endtask

    task automatic wait_resp(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic set_op(input int idx, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[idx*SZ +: SZ] = a;
        bus.req_b[idx*SZ +: SZ] = b;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ok;
        int order[$];
        int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

        _rst          = 1'b0;
        stub_rst_n    = 1'b0;
        stub_lat      = 8;
        stub_hold     = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        #12 stub_rst_n = 1'b1;
        do_reset();

        // Single request from requester 2: 3 * 5.
        set_op(2, 32'd3, 32'd5);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check("t1_grant", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        check("t1_start", bus.m_start, 1);
        wait_resp(40, ok);
        check("t1_resp_seen", ok, 1);
        check("t1_data", bus.res_data, 64'd15);
        check("t1_id",   bus.res_id,   2);
        check("t1_err",  bus.res_err,  0);
        tick();
        drain();

        // All four requesting after reset: strict rotation starting at 0.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1) * 11, 32'(i + 3));
        stub_lat      = 2;
        bus.req_valid = 4'hF;
        for (int c = 0; c < 400 && order.size() < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) order.push_back(i);
            tick();
        end
        bus.req_valid = '0;
        check("t2_grant_count", order.size(), 8);
        for (int i = 0; i < 8 && i < order.size(); i++) check("t2_grant_order", order[i], exp_order[i]);
        drain();

        // Maximum operands.
        set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check("t3_grant", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        wait_resp(40, ok);
        check("t3_resp_seen", ok, 1);
        check("t3_data", bus.res_data, 64'hFFFF_FFFE_0000_0001);
        tick();
        drain();

        // Backpressure: consumer stalls 10 cycles while everyone requests.
        set_op(3, 32'd7, 32'd9);
        bus.res_ready = 1'b0;
        bus.req_valid = 4'b1000;
        @(negedge clk);
        check("t4_grant", bus.req_ready, 4'b1000);
        tick();
        bus.req_valid = 4'hF;
        wait_resp(40, ok);
        check("t4_resp_seen", ok, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("t4_hold_valid", bus.res_valid, 1);
            check("t4_hold_data",  bus.res_data,  64'd63);
            check("t4_hold_id",    bus.res_id,    3);
            check("t4_no_grant",   bus.req_ready, 0);
        end
        tick();
        bus.res_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("t4_resume_grant", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        drain();

        // Reset while waiting on the multiplier.
        stub_lat = 20;
        set_op(1, 32'd2, 32'd2);
        bus.req_valid = 4'b0010;
        @(negedge clk);
        check("t5_grant", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        repeat (6) tick();
        stub_lat = 3;
        _rst     = 1'b0;
        @(negedge clk);
        check("t5_rst_res_valid", bus.res_valid, 0);
        check("t5_rst_m_start",   bus.m_start,   0);
        tick();
        _rst          = 1'b1;
        bus.req_valid = 4'hF;
        @(negedge clk);
        check("t5_grant_after_rst", bus.req_ready, 4'b0001);
        check("t5_no_stale_valid",  bus.res_valid, 0);
        tick();
        bus.req_valid = '0;
        drain();

        // Multiplier that never becomes ready.
        stub_lat  = 2;
        stub_hold = 1'b1;
        set_op(2, 32'd6, 32'd7);
        bus.req_valid = 4'b0100;
        @(negedge clk);
        check("t6_grant", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
`ifdef MULT_ARB_TIMEOUT_EN
        wait_resp(TIMEOUT + 20, ok);
        check("t6_timeout_seen", ok, 1);
        check("t6_err",  bus.res_err,  1);
        check("t6_data", bus.res_data, 0);
        check("t6_id",   bus.res_id,   2);
        tick();
        stub_hold = 1'b0;
`else
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check("t6_still_waiting", bus.res_valid, 0);
        end
        stub_hold = 1'b0;
        wait_resp(20, ok);
        check("t6_resp_seen", ok, 1);
        check("t6_data", bus.res_data, 64'd42);
        check("t6_err",  bus.res_err,  0);
        tick();
`endif
        drain();

        // Randomized traffic, backpressure, latencies and occasional reset.
        for (int c = 0; c < 3000; c++) begin
            tick();
            _rst          = ($urandom_range(0, 499) != 0);
            bus.req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom);
            bus.res_ready = ($urandom_range(0, 3) != 0);
            stub_lat      = $urandom_range(1, 6);
        end
        _rst = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_rr_arbiter.md
# mult_rr_arbiter

Round-robin controller that shares one `mult` instance (SZ×SZ → 2·SZ sequential multiplier with `start`/`ready` handshake) among NREQ requesters. It accepts operand pairs over valid/ready channels, sequences the multiplier's start/ready protocol, and returns each product on a single tagged response channel. It sits between the bus-facing slave wrappers and the multiplier core.

## Interface
Parameters:
- `SZ`, 32, operand width; product is 2·SZ.
- `NREQ`, 4, number of requesters (≥2); `IDW` = $clog2(NREQ).
- `TIMEOUT`, 255, watchdog limit in cycles; used only with `MULT_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all logic rising-edge.
- `_rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester operand valid.
- `req_a`  in  NREQ·SZ  operand a, requester i at [i·SZ +: SZ].
- `req_b`  in  NREQ·SZ  operand b, same packing.
- `req_ready`  out  NREQ  one-hot accept; at most one bit high.
- `res_valid`  out  1  product available.
- `res_data`  out  2·SZ  product.
- `res_id`  out  IDW  index of the requester that owns the product.
- `res_err`  out  1  timeout flag; constant 0 without the macro.
- `res_ready`  in  1  response consumer accepts.
- `m_a`, `m_b`  out  SZ  multiplier operands.
- `m_start`  out  1  multiplier start pulse.
- `m_res`  in  2·SZ  multiplier product.
- `m_ready`  in  1  multiplier idle / result valid (low while busy).

## Operation
- States: IDLE, START, SETTLE, WAIT, RESP.
- IDLE: grant = first i with `req_valid[i]`=1, searching from `last+1` mod NREQ and wrapping. `req_ready[grant]`=1 combinationally in the same cycle. On the handshake, the block latches a, b and id, updates `last`=grant, and moves to START. With no request valid, it stays in IDLE.
- START: `m_start`=1 for exactly one cycle. `m_a`/`m_b` are driven from latched registers and held stable until the block leaves WAIT. Next state is SETTLE.
- SETTLE: one cycle in which `m_ready` is ignored, because the multiplier may drop ready one cycle after start. Next state is WAIT.
- WAIT: on `m_ready`=1, the block captures `m_res` into `res_data` and moves to RESP.
- RESP: `res_valid`=1. `res_data`, `res_id` and `res_err` are held stable until `res_ready`=1, then the block returns to IDLE. No new grant is issued while in RESP, so backpressure stalls all requesters.
- Only one operation is in flight; `req_ready` is all-zero outside IDLE.
- Fairness: a continuously requesting requester is granted at least once every NREQ operations.
- `req_valid` dropping before its grant is legal; the request is simply not served.

## Timing
- Reset values: `req_ready`=0, `res_valid`=0, `res_data`=0, `res_id`=0, `res_err`=0, `m_start`=0, `m_a`=0, `m_b`=0, state=IDLE, `last`=NREQ-1 (requester 0 has first priority).
- Reset mid-operation (any state) aborts immediately: the latched op is discarded, no response is produced, and the multiplier is left to finish unobserved.
- Latency, with accept in cycle T:
  - `m_start` in T+1.
  - Earliest `m_ready` sample in T+3.
  - `res_valid` one cycle after `m_ready` is sampled; minimum T+4.
- Response handshake completes in cycle R; next accept is possible in R+1.
- Simultaneous requests are resolved only by the round-robin pointer; the index order is used only after reset.

## Configuration
- `MULT_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If `m_ready` is not seen within TIMEOUT cycles after entering WAIT, the block goes to RESP with `res_err`=1 and `res_data`=0.
  - The counter clears on every WAIT entry.
- Not defined:
  - No counter; WAIT is unbounded.
  - `res_err` is tied to 0.

## Test plan
- Single request: req 2, a=3, b=5, `res_ready`=1, multiplier stub with 8-cycle latency → `req_ready`=0100 in T, `m_start` in T+1, then `res_valid` with `res_data`=15, `res_id`=2, `res_err`=0.
- All four requesters held valid for 8 operations after reset → grant order 0,1,2,3,0,1,2,3; products match per-requester operands.
- Maximum operands a=b=0xFFFFFFFF → `res_data`=0xFFFFFFFE00000001.
- Backpressure: `res_ready`=0 for 10 cycles during RESP → `res_valid` and data stable, `req_ready` stays 0; accept resumes the cycle after `res_ready`=1.
- `_rst` asserted during WAIT then released → all outputs at reset values; no stale `res_valid`; the next grant goes to requester 0.
- With `MULT_ARB_TIMEOUT_EN`, stub holding `m_ready`=0 → after 255 cycles `res_valid`=1, `res_err`=1, `res_data`=0; without the macro the block remains in WAIT.
